pong_engine: RTL and testbench
==============================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 Parameter SCREEN_W, default 160: playfield width in cells; x range 0..SCREEN_W-1.
REQ-002 Parameter SCREEN_H, default 120: playfield height in cells; y range 0..SCREEN_H-1.
REQ-003 Parameter COORD_W, default 8: coordinate register width; must hold SCREEN_W-1 and SCREEN_H-1.
REQ-004 Parameter PADDLE_HALF, default 4: paddle half-extent; paddle covers centre ±PADDLE_HALF.
REQ-005 Parameter TICK_DIV, default 1024: enabled clocks per game tick, minimum 2.
REQ-006 Parameter SERVE_TICKS, default 32: ticks spent in SERVE before play.
REQ-007 Parameter WIN_SCORE, default 7: score that ends the game, maximum 15.
REQ-008 Port clk, input, 1: single clock; all state on its rising edge.
REQ-009 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-010 Port ena, input, 1: when low, tick counter, FSM, ball and paddles hold; dout still updates.
REQ-011 Ports left_up, left_down, right_up, right_down, input, 1 each: level paddle commands.
REQ-012 Port start, input, 1: game start/restart; rising edge acted on.
REQ-013 Port sel, input, 3: output select.
REQ-014 Port dout, output, 8: registered selected value.
REQ-015 Port state, output, 3: FSM state code.
REQ-016 Ports point_left, point_right, output, 1 each: one-clock pulse when that player scores.

Function
REQ-017 Tick: counter 0..TICK_DIV-1, advances only when ena=1; tick=1 for one clock when counter==TICK_DIV-1 and ena=1; counter then wraps to 0.
REQ-018 Start edge: start registered; start_rise = start & ~start_q, one clock.
REQ-019 FSM states and codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-020 IDLE: ball at (SCREEN_W/2, SCREEN_H/2), paddles at SCREEN_H/2, scores 0; start_rise -> SERVE with serve count 0.
REQ-021 SERVE: ball held at centre; serve count increments per tick; at SERVE_TICKS ticks -> PLAY with vx = serve direction, vy=+1.
REQ-022 Serve direction: +1 (toward right) after reset and restart; after a point, toward the player who conceded.
REQ-023 Paddles move on ticks in SERVE and PLAY only: up -> −1, down -> +1, both or neither -> hold; clamp to [PADDLE_HALF, SCREEN_H-1-PADDLE_HALF].
REQ-024 PLAY, ball y per tick: y==0 with vy=-1 -> vy=+1, y=1; y==SCREEN_H-1 with vy=+1 -> vy=-1, y=SCREEN_H-2; else y+=vy.
REQ-025 PLAY, ball x per tick: x==1, vx=-1, |y - left_y| <= PADDLE_HALF -> vx=+1, x=2; x==1, vx=-1, miss -> x=0, go POINT, right scores.
REQ-026 Mirror: x==SCREEN_W-2, vx=+1, hit on right paddle -> vx=-1, x=SCREEN_W-3; miss -> x=SCREEN_W-1, POINT, left scores.
REQ-027 Hit test uses pre-tick ball y and pre-tick paddle position; y-bounce and x-bounce in the same tick both apply.
REQ-028 POINT lasts exactly one clock: scorer's 4-bit score +1, matching point_* pulses that clock; if new score == WIN_SCORE -> OVER, else -> SERVE with serve count 0.
REQ-029 OVER: all motion frozen, scores held; start_rise -> scores cleared, SERVE, serve direction +1.
REQ-030 start_rise in SERVE or PLAY: ignored.
REQ-031 Output mux, dout registered one clock after sel: 0 ball_x, 1 ball_y, 2 left paddle, 3 right paddle, 4 {left_score, right_score}, 5 {state, 3'b0, vx==+1, vy==+1}, 6/7 8'h00; coordinates zero-extended or truncated to 8 bits.
REQ-032 Velocities stored as single direction bits; all position arithmetic in COORD_W bits, never wrapping due to clamps above.

Reset
REQ-033 rst_n low, asynchronously: state=IDLE, tick counter 0, start_q 0, scores 0, ball at centre, paddles at SCREEN_H/2, vx=+1, vy=+1, dout=8'h00, point_left=point_right=0.
REQ-034 Reset mid-game discards all progress; first edge after release evaluates from IDLE; a start held high across release is not an edge.

Verification (bench uses SCREEN_W=16, SCREEN_H=12, PADDLE_HALF=1, TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=3)
REQ-035 Reset, sel=5 -> dout=8'h03; sel=0 -> 8; sel=1 -> 6; state=0.
REQ-036 start pulse, no paddle input -> state 1 for 8 enabled clocks, then 2; ball_x 9,10,... every 4 clocks.
REQ-037 Right paddle parked at 6, ball arrives x=14 y=6 -> vx flips, next x=13, no point pulse.
REQ-038 Right paddle parked at 1 (up held), ball misses -> x=15, point_left one clock, sel=4 -> 8'h10, next serve vx=+1 toward right.
REQ-039 Left reaches 3 points -> state 4, start held high 20 clocks no motion; start low then high -> scores 8'h00, state 1.
REQ-040 ena=0 for 50 clocks during PLAY -> ball, paddles, tick counter unchanged; up and down both held -> paddle holds; paddle up held -> stops at 1.

Source files
------------

// File: rtl/pong_engine.sv
// Single-player-pair pong game engine: a game tick derived from the enable,
// a five-state game FSM, and the ball, paddle and score registers.
// dout is a registered view of one game variable, chosen by sel.
module pong_engine #(
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int COORD_W     = 8,
    parameter int PADDLE_HALF = 4,
    parameter int TICK_DIV    = 1024,
    parameter int SERVE_TICKS = 32,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       left_up,
    input  logic       left_down,
    input  logic       right_up,
    input  logic       right_down,
    input  logic       start,
    input  logic [2:0] sel,
    output logic [7:0] dout,
    output logic [2:0] state,
    output logic       point_left,
    output logic       point_right
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SRV_W = $clog2(SERVE_TICKS + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_TICKS - 1);
    localparam logic [COORD_W-1:0] CX       = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0] CY       = COORD_W'(SCREEN_H / 2);
    localparam logic [COORD_W-1:0] X_LEFT   = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_RIGHT  = COORD_W'(SCREEN_W - 2);
    localparam logic [COORD_W-1:0] X_LBOUNCE = COORD_W'(2);
    localparam logic [COORD_W-1:0] X_RBOUNCE = COORD_W'(SCREEN_W - 3);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(SCREEN_H - 1);
    localparam logic [COORD_W-1:0] Y_BOTTOM_BOUNCE = COORD_W'(SCREEN_H - 2);
    localparam logic [COORD_W-1:0] PAD_MIN  = COORD_W'(PADDLE_HALF);
    localparam logic [COORD_W-1:0] PAD_MAX  = COORD_W'(SCREEN_H - 1 - PADDLE_HALF);
    localparam logic [COORD_W:0]   HALF     = (COORD_W + 1)'(PADDLE_HALF);
    localparam logic [3:0]         WIN      = 4'(WIN_SCORE);

    // Ball row within paddle reach; one extra bit keeps the sums from wrapping.
    function automatic logic paddle_hit(input logic [COORD_W-1:0] by,
                                        input logic [COORD_W-1:0] py);
        logic [COORD_W:0] b;
        logic [COORD_W:0] p;
        b = {1'b0, by};
        p = {1'b0, py};
        return ((b + HALF) >= p) && ((p + HALF) >= b);
    endfunction

    // One step of paddle motion; opposing commands cancel, clamps keep the
    // paddle fully on screen.
    function automatic logic [COORD_W-1:0] paddle_move(input logic [COORD_W-1:0] p,
                                                       input logic up,
                                                       input logic down);
        logic [COORD_W-1:0] r;
        r = p;
        if (up && !down && (p > PAD_MIN))
            r = p - COORD_W'(1);
        else if (down && !up && (p < PAD_MAX))
            r = p + COORD_W'(1);
        return r;
    endfunction

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic               start_q;
    logic               armed;
    logic               start_rise;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [COORD_W-1:0] left_y;
    logic [COORD_W-1:0] right_y;
    logic               vx;
    logic               vy;
    logic [3:0]         left_score;
    logic [3:0]         right_score;
    logic [3:0]         new_score;
    logic [SRV_W-1:0]   serve_cnt;
    logic               serve_dir;
    logic               scorer_left;
    logic               left_hit;
    logic               right_hit;
    logic               at_left;
    logic               at_right;
    logic               left_miss;
    logic               right_miss;

    // armed blocks the first clock after reset so a start held across release
    // is not mistaken for a press.
    assign tick       = ena && (tick_cnt == CNT_LAST);
    assign start_rise = start && !start_q && armed;
    assign left_hit   = paddle_hit(ball_y, left_y);
    assign right_hit  = paddle_hit(ball_y, right_y);
    assign at_left    = !vx && (ball_x == X_LEFT);
    assign at_right   = vx && (ball_x == X_RIGHT);
    assign left_miss  = at_left && !left_hit;
    assign right_miss = at_right && !right_hit;
    assign new_score  = (scorer_left ? left_score : right_score) + 4'd1;

    // Tick divider and start-edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            start_q  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            start_q <= start;
            armed   <= 1'b1;
            if (ena)
                tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // FSM next-state logic; everything holds while ena is low.
    always_comb begin
        state_next = state_reg;
        if (ena) begin
            case (state_reg)
                IDLE:    if (start_rise) state_next = SERVE;
                SERVE:   if (tick && (serve_cnt == SRV_LAST)) state_next = PLAY;
                PLAY:    if (tick && (left_miss || right_miss)) state_next = POINT;
                POINT:   state_next = (new_score == WIN) ? OVER : SERVE;
                OVER:    if (start_rise) state_next = SERVE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: state code and the one-clock scoring pulses.
    always_comb begin
        state       = 3'(state_reg);
        point_left  = ena && (state_reg == POINT) && scorer_left;
        point_right = ena && (state_reg == POINT) && !scorer_left;
    end

    // Ball motion, serve sequencing and scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x      <= CX;
            ball_y      <= CY;
            vx          <= 1'b1;
            vy          <= 1'b1;
            left_score  <= '0;
            right_score <= '0;
            serve_cnt   <= '0;
            serve_dir   <= 1'b1;
            scorer_left <= 1'b0;
        end else if (ena) begin
            case (state_reg)
                IDLE: begin
                    ball_x      <= CX;
                    ball_y      <= CY;
                    left_score  <= '0;
                    right_score <= '0;
                    serve_cnt   <= '0;
                    serve_dir   <= 1'b1;
                end
                SERVE: begin
                    ball_x <= CX;
                    ball_y <= CY;
                    if (tick) begin
                        if (serve_cnt == SRV_LAST) begin
                            serve_cnt <= '0;
                            vx        <= serve_dir;
                            vy        <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt + SRV_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (!vy && (ball_y == '0)) begin
                            vy     <= 1'b1;
                            ball_y <= COORD_W'(1);
                        end else if (vy && (ball_y == Y_MAX)) begin
                            vy     <= 1'b0;
                            ball_y <= Y_BOTTOM_BOUNCE;
                        end else begin
                            ball_y <= vy ? ball_y + COORD_W'(1) : ball_y - COORD_W'(1);
                        end

                        if (at_left) begin
                            if (left_hit) begin
                                vx     <= 1'b1;
                                ball_x <= X_LBOUNCE;
                            end else begin
                                ball_x      <= '0;
                                scorer_left <= 1'b0;
                            end
                        end else if (at_right) begin
                            if (right_hit) begin
                                vx     <= 1'b0;
                                ball_x <= X_RBOUNCE;
                            end else begin
                                ball_x      <= X_MAX;
                                scorer_left <= 1'b1;
                            end
                        end else begin
                            ball_x <= vx ? ball_x + COORD_W'(1) : ball_x - COORD_W'(1);
                        end
                    end
                end
                POINT: begin
                    if (scorer_left)
                        left_score <= new_score;
                    else
                        right_score <= new_score;
                    // The next serve heads toward whoever conceded.
                    serve_dir <= scorer_left;
                    serve_cnt <= '0;
                end
                OVER: begin
                    if (start_rise) begin
                        left_score  <= '0;
                        right_score <= '0;
                        serve_dir   <= 1'b1;
                        serve_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Paddles: centred while idle, stepped on ticks during serve and play.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_y  <= CY;
            right_y <= CY;
        end else if (ena) begin
            if (state_reg == IDLE) begin
                left_y  <= CY;
                right_y <= CY;
            end else if (tick && ((state_reg == SERVE) || (state_reg == PLAY))) begin
                left_y  <= paddle_move(left_y, left_up, left_down);
                right_y <= paddle_move(right_y, right_up, right_down);
            end
        end
    end

    // Registered output mux; runs regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else begin
            case (sel)
                3'd0:    dout <= 8'(ball_x);
                3'd1:    dout <= 8'(ball_y);
                3'd2:    dout <= 8'(left_y);
                3'd3:    dout <= 8'(right_y);
                3'd4:    dout <= {left_score, right_score};
                3'd5:    dout <= {3'(state_reg), 3'b000, vx, vy};
                default: dout <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine on a 16x12 field: serve timing, ball travel,
// paddle hits and misses, scoring to game over, restart, enable hold and reset.
module tb_pong_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       left_up = 1'b0;
    logic       left_down = 1'b0;
    logic       right_up = 1'b0;
    logic       right_down = 1'b0;
    logic       start = 1'b0;
    logic [2:0] sel = 3'd5;
    logic [7:0] dout;
    logic [2:0] state;
    logic       point_left;
    logic       point_right;

    int vectors = 0;
    int miscompares = 0;
    int ee = 0;   // enabled clock edges since reset release

    pong_engine #(
        .SCREEN_W(16), .SCREEN_H(12), .COORD_W(8), .PADDLE_HALF(1),
        .TICK_DIV(4), .SERVE_TICKS(2), .WIN_SCORE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .left_up(left_up), .left_down(left_down),
        .right_up(right_up), .right_down(right_down),
        .start(start), .sel(sel), .dout(dout), .state(state),
        .point_left(point_left), .point_right(point_right)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (ee=%0d)", tag, got, exp, ee);
        end else begin
            $display("ok   %s: 0x%0h (ee=%0d)", tag, got, ee);
        end
    endtask

    task automatic step();
        logic en;
        en = ena;
        @(posedge clk);
        #1;
        if (en) ee++;
    endtask

    task automatic goto_ee(input int target);
        int guard;
        guard = 0;
        while (ee < target && guard < 2000) begin
            step();
            guard++;
        end
    endtask

    // dout after one clock shows the selected value as it was before that clock.
    task automatic peek(input logic [2:0] s, input string tag, input logic [7:0] exp);
        sel = s;
        step();
        check(tag, dout, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_dout", dout, 8'h00);
        check("rst_point_left", point_left, 0);
        check("rst_point_right", point_right, 0);
        rst_n = 1'b1;
        ee = 0;

        peek(5, "rst_status", 8'h03);
        peek(0, "rst_ball_x", 8'd8);
        peek(1, "rst_ball_y", 8'd6);
        check("idle_state", state, 0);

        // start seen on the tick edge: 8 clocks of SERVE, then PLAY
        start = 1'b1;
        for (int i = 4; i <= 11; i++) begin
            step();
            check($sformatf("serve_state_e%0d", i), state, 1);
            if (i == 4) start = 1'b0;
        end
        step();
        check("play_entry", state, 2);

        right_up = 1'b1;
        goto_ee(16); peek(0, "ball_x_t1", 8'd9);
        goto_ee(20); peek(0, "ball_x_t2", 8'd10);
        goto_ee(36); peek(3, "right_pad_clamped", 8'd1);

        // right paddle at 1, ball at y=10 misses: left scores
        goto_ee(40);
        check("miss1_state", state, 3);
        check("miss1_point_left", point_left, 1);
        check("miss1_point_right", point_right, 0);
        peek(0, "miss1_x", 8'd15);
        check("miss1_serve_state", state, 1);
        check("miss1_pulse_done", point_left, 0);
        right_up = 1'b0;
        right_down = 1'b1;
        peek(4, "score_1_0", 8'h10);
        goto_ee(48); peek(5, "serve2_status", 8'h43);

        // right paddle to 9 to meet the ball at y=10
        goto_ee(72);
        right_down = 1'b0;
        peek(3, "right_pad_9", 8'd9);
        goto_ee(76);
        check("hit1_state", state, 2);
        check("hit1_no_point", point_left, 0);
        peek(0, "hit1_x", 8'd13);

        // park right at 6, left at 4
        right_up = 1'b1;
        goto_ee(88);
        right_up = 1'b0;
        left_up = 1'b1;
        goto_ee(96);
        left_up = 1'b0;
        peek(2, "left_pad_4", 8'd4);
        peek(3, "right_pad_6", 8'd6);

        goto_ee(128);
        check("left_hit_state", state, 2);
        check("left_hit_no_point", point_right, 0);
        peek(0, "left_hit_x", 8'd2);

        // ball arrives x=14 y=6 at the right paddle parked at 6
        goto_ee(176);
        peek(0, "arrive_x", 8'd14);
        peek(1, "arrive_y", 8'd6);
        goto_ee(180);
        check("bounce_state", state, 2);
        check("bounce_no_point", point_left, 0);
        peek(0, "bounce_x", 8'd13);
        peek(5, "bounce_status", 8'h40);

        // enable low: nothing moves even with a paddle command
        ena = 1'b0;
        left_up = 1'b1;
        repeat (50) step();
        peek(0, "hold_x", 8'd13);
        peek(1, "hold_y", 8'd5);
        peek(2, "hold_left", 8'd4);
        peek(3, "hold_right", 8'd6);
        check("hold_state", state, 2);
        left_down = 1'b1;
        ena = 1'b1;

        goto_ee(188); peek(2, "both_held", 8'd4);
        left_up = 1'b0;
        goto_ee(200);
        left_down = 1'b0;
        peek(2, "left_pad_7", 8'd7);

        goto_ee(232);
        check("left_hit2_state", state, 2);
        check("left_hit2_no_point", point_right, 0);
        peek(0, "left_hit2_x", 8'd2);

        goto_ee(284);
        check("miss2_state", state, 3);
        check("miss2_point_left", point_left, 1);
        check("miss2_point_right", point_right, 0);
        step();
        check("miss2_serve_state", state, 1);
        peek(4, "score_2_0", 8'h20);

        goto_ee(296);
        start = 1'b1;
        step();
        check("start_in_play_ignored", state, 2);

        goto_ee(320);
        check("miss3_state", state, 3);
        check("miss3_point_left", point_left, 1);
        step();
        check("over_state", state, 4);
        peek(4, "final_score", 8'h30);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("over_hold_%0d", i), state, 4);
        end
        peek(0, "over_x_frozen", 8'd15);

        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check("restart_state", state, 1);
        peek(4, "restart_scores", 8'h00);

        // asynchronous reset mid-game with start held high across release
        rst_n = 1'b0;
        #2;
        check("async_rst_state", state, 0);
        check("async_rst_dout", dout, 8'h00);
        check("async_rst_point", point_left, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        check("held_start_not_edge", state, 0);
        peek(5, "post_reset_status", 8'h03);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
